// File: rtl/audio_pkg.sv
// Shared types and constants for the audio sample path (scheduler and audio_pwm).
package audio_pkg;

  typedef logic [7:0] sample_t;

  // Mid-scale of the unsigned PWM range; the speaker rests here.
  localparam sample_t SILENCE = 8'd128;

  typedef enum logic [1:0] {IDLE, PLAY, HOLD, FADE} sched_state_e;

  // Defaults shared with audio_pwm so both wrap on the same cycle.
  localparam int unsigned DEF_PERIOD_CYCLES = 256;
  localparam int unsigned DEF_DIV           = 12;

  // One step of the fade ramp toward SILENCE.
  function automatic sample_t fade_step(input sample_t s);
    if (s > SILENCE) begin
      return s - 8'd1;
    end else if (s < SILENCE) begin
      return s + 8'd1;
    end
    return s;
  endfunction

endpackage

// File: rtl/audio_tick_gen.sv
// PWM period counter and sample divider; tick fires on the last cycle of every DIV-th period.
module audio_tick_gen
  import audio_pkg::*;
#(
  parameter int unsigned PERIOD_CYCLES = DEF_PERIOD_CYCLES,
  parameter int unsigned DIV           = DEF_DIV
) (
  input  logic clk,
  input  logic reset,
  output logic tick,
  output logic period_wrap
);

  localparam int unsigned PW = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
  localparam int unsigned DW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [PW-1:0] period_q;
  logic [DW-1:0] div_q;

  assign period_wrap = (period_q == PW'(PERIOD_CYCLES - 1));
  assign tick        = period_wrap && (div_q == DW'(DIV - 1));

  // Period counter free-runs; the divider steps once per period wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      period_q <= '0;
      div_q    <= '0;
    end else begin
      period_q <= period_wrap ? '0 : period_q + PW'(1);
      if (period_wrap) begin
        div_q <= (div_q == DW'(DIV - 1)) ? '0 : div_q + DW'(1);
      end
    end
  end

endmodule

// File: rtl/audio_sample_sched.sv
// Sample-rate scheduler feeding audio_pwm: per-tick source arbitration, underrun hold and fade.
// Build option AUDIO_SCHED_MIX_EN: accept every valid source each tick and output their
// saturated sum around SILENCE instead of a fixed-priority single source.
module audio_sample_sched
  import audio_pkg::*;
#(
  parameter int unsigned NUM_SRC       = 4,
  parameter int unsigned PERIOD_CYCLES = DEF_PERIOD_CYCLES,
  parameter int unsigned DIV           = DEF_DIV,
  parameter int unsigned HOLD_TICKS    = 64,
  localparam int unsigned SRC_W        = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_SRC-1:0]   src_valid,
  input  logic [8*NUM_SRC-1:0] src_data,
  output logic [NUM_SRC-1:0]   src_ready,
  input  logic                 mute,
  output logic [7:0]           music_data,
  output logic                 sample_strobe,
  output logic                 underrun,
  output logic [SRC_W-1:0]     active_src
);

  localparam int unsigned HW = (HOLD_TICKS > 2) ? $clog2(HOLD_TICKS) : 1;

  logic tick, period_wrap, sample_tick;

  audio_tick_gen #(
    .PERIOD_CYCLES(PERIOD_CYCLES),
    .DIV          (DIV)
  ) u_tick_gen (
    .clk        (clk),
    .reset      (reset),
    .tick       (tick),
    .period_wrap(period_wrap)
  );

  // Updates only ever land on a PWM period boundary.
  assign sample_tick = tick && period_wrap;

  sched_state_e     state_q, state_d;
  sample_t          music_q, music_d;
  logic             strobe_q, strobe_d;
  logic             underrun_q, underrun_d;
  logic [SRC_W-1:0] active_q, active_d;
  logic [HW-1:0]    hold_q, hold_d;

  logic             any_valid;
  logic [SRC_W-1:0] first_idx;
  sample_t          new_sample;
  logic [NUM_SRC-1:0] grant;

  assign any_valid = |src_valid;

`ifdef AUDIO_SCHED_MIX_EN
  localparam int unsigned ACC_W = 8 + $clog2(NUM_SRC) + 1;
  logic signed [ACC_W-1:0] acc;

  // Lowest valid index plus the saturated sum of all valid sources around SILENCE.
  always_comb begin
    first_idx = '0;
    acc       = ACC_W'(signed'(10'sd128));
    for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
      if (src_valid[i]) begin
        first_idx = SRC_W'(i);
      end
    end
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      if (src_valid[i]) begin
        acc = acc + ACC_W'($signed({1'b0, src_data[8*i +: 8]})) - ACC_W'(signed'(10'sd128));
      end
    end
    if (acc < 0) begin
      new_sample = 8'd0;
    end else if (acc > 255) begin
      new_sample = 8'd255;
    end else begin
      new_sample = acc[7:0];
    end
    grant = (sample_tick && !mute) ? src_valid : '0;
  end
`else
  // Fixed priority: index 0 wins, others stall to a later tick.
  always_comb begin
    first_idx  = '0;
    new_sample = SILENCE;
    for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
      if (src_valid[i]) begin
        first_idx  = SRC_W'(i);
        new_sample = src_data[8*i +: 8];
      end
    end
    grant = '0;
    if (sample_tick && !mute && any_valid) begin
      grant[first_idx] = 1'b1;
    end
  end
`endif

  assign src_ready = grant;

  // Next-state and registered outputs; nothing changes outside the tick cycle.
  always_comb begin
    state_d    = state_q;
    music_d    = music_q;
    strobe_d   = 1'b0;
    underrun_d = 1'b0;
    active_d   = active_q;
    hold_d     = hold_q;
    if (sample_tick) begin
      if (mute) begin
        state_d  = IDLE;
        music_d  = SILENCE;
        strobe_d = (music_q != SILENCE);
        hold_d   = '0;
      end else if (any_valid) begin
        state_d  = PLAY;
        music_d  = new_sample;
        strobe_d = 1'b1;
        active_d = first_idx;
        hold_d   = '0;
      end else begin
        unique case (state_q)
          IDLE: ;
          PLAY: begin
            state_d    = (HOLD_TICKS > 1) ? HOLD : FADE;
            hold_d     = '0;
            underrun_d = 1'b1;
          end
          HOLD: begin
            underrun_d = 1'b1;
            hold_d     = hold_q + HW'(1);
            if (int'(hold_q) + 1 >= int'(HOLD_TICKS) - 1) begin
              state_d = FADE;
            end
          end
          FADE: begin
            music_d  = fade_step(music_q);
            strobe_d = (music_q != SILENCE);
            if (fade_step(music_q) == SILENCE) begin
              state_d = IDLE;
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      music_q    <= SILENCE;
      strobe_q   <= 1'b0;
      underrun_q <= 1'b0;
      active_q   <= '0;
      hold_q     <= '0;
    end else begin
      state_q    <= state_d;
      music_q    <= music_d;
      strobe_q   <= strobe_d;
      underrun_q <= underrun_d;
      active_q   <= active_d;
      hold_q     <= hold_d;
    end
  end

  assign music_data    = music_q;
  assign sample_strobe = strobe_q;
  assign underrun      = underrun_q;
  assign active_src    = active_q;

endmodule
